// File: rtl/wr_stage_pipe_pkg.sv
// Shared encodings and helpers for the write-back stage.
// Codes match the wb_sel_i and load_type_i fields produced by decode.
package wr_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_AUX  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BS = 3'b001,
        LD_BU = 3'b010,
        LD_HS = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

    // Unused load-type codes get word alignment rules, matching load_extend.
    function automatic logic is_misaligned(input logic [2:0] load_type, input logic [1:0] addr_lo);
        case (load_type)
            LD_BS, LD_BU: return 1'b0;
            LD_HS, LD_HU: return addr_lo[0];
            default:      return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/wr_stage_pipe_if.sv
// MEM-to-WB stage bundle: stage inputs from MEM plus the register-file/forwarding outputs.
interface wr_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // No upstream backpressure: in_valid_i qualifies each capture; stall_i holds the
    // WB register, flush_i kills the capture and wins over stall_i.
    logic              in_valid_i;
    logic              stall_i;
    logic              flush_i;
    logic [DATA_W-1:0] alu_ans_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] pc_addr_i;
    logic [DATA_W-1:0] aux_data_i;
    logic [1:0]        wb_sel_i;
    logic [2:0]        load_type_i;
    logic              reg_we_i;
    logic [REG_AW-1:0] rd_i;
    logic              wr_en_o;
    logic [REG_AW-1:0] wr_addr_o;
    logic [DATA_W-1:0] busW_o;
    logic              misalign_o;
    logic [CNT_W-1:0]  retire_cnt_o;

    modport master (
        output in_valid_i, stall_i, flush_i, alu_ans_i, mem_data_i, pc_addr_i,
               aux_data_i, wb_sel_i, load_type_i, reg_we_i, rd_i,
        input  wr_en_o, wr_addr_o, busW_o, misalign_o, retire_cnt_o
    );

    modport slave (
        input  in_valid_i, stall_i, flush_i, alu_ans_i, mem_data_i, pc_addr_i,
               aux_data_i, wb_sel_i, load_type_i, reg_we_i, rd_i,
        output wr_en_o, wr_addr_o, busW_o, misalign_o, retire_cnt_o
    );

endinterface

// File: rtl/wr_stage_pipe_load_extend.sv
// Little-endian byte/half extraction with sign or zero extension from an aligned word.
module load_extend
    import wr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_load_type,
    output logic [DATA_W-1:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_load_type)
            LD_BS:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_BU:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LD_HS:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_HU:   o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/wr_stage_pipe.sv
// Write-back stage: source mux, MEM/WB register with stall/flush, write enable
// generation, misalignment pulse and retire counter.
module wr_stage_pipe
    import wr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_OFF = 8,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wr_stage_pipe_if.slave bus
);
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_src;
    logic              w_misaligned;
    logic              w_wr_en;

    logic              r_wr_en;
    logic [REG_AW-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_busW;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_retire_cnt;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_word      (bus.mem_data_i),
        .i_addr_lo   (bus.alu_ans_i[1:0]),
        .i_load_type (bus.load_type_i),
        .o_data      (w_load_data)
    );

    always_comb begin
        w_misaligned = (bus.wb_sel_i == WB_MEM) && is_misaligned(bus.load_type_i, bus.alu_ans_i[1:0]);
        case (bus.wb_sel_i)
            WB_ALU:  w_src = bus.alu_ans_i;
            WB_MEM:  w_src = w_load_data;
            WB_LINK: w_src = bus.pc_addr_i + DATA_W'(LINK_OFF);
            default: w_src = bus.aux_data_i;
        endcase
        w_wr_en = bus.in_valid_i & bus.reg_we_i & (bus.rd_i != '0) & ~w_misaligned;
    end

    // Flush only kills the write; data/address registers keep stale, don't-care values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_busW       <= '0;
            r_misalign   <= 1'b0;
            r_retire_cnt <= '0;
        end else if (bus.flush_i) begin
            r_wr_en    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (bus.stall_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= bus.rd_i;
            r_busW     <= w_src;
            r_misalign <= bus.in_valid_i & w_misaligned;
            if (bus.in_valid_i) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.wr_en_o      = r_wr_en;
    assign bus.wr_addr_o    = r_wr_addr;
    assign bus.busW_o       = r_busW;
    assign bus.misalign_o   = r_misalign;
    assign bus.retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_wr_stage_pipe.sv
// Bench for wr_stage_pipe (4-bit retire counter build): directed scenarios plus a
// randomized stream against a transaction-level reference model.
module tb_wr_stage_pipe;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int LOFF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wr_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

    wr_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .LINK_OFF(LOFF), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the outputs should show after the next edge.
    logic          m_we;
    logic          m_mis;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_bus;
    int            m_cnt;

    function automatic logic [31:0] ref_src(input logic [1:0] sel, input logic [2:0] lt,
                                            input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [31:0] pc, input logic [31:0] aux);
        logic [31:0] v;
        int lo;
        lo = int'(alu[1:0]);
        case (sel)
            2'd0: return alu;
            2'd2: return pc + 32'(LOFF);
            2'd3: return aux;
            default: begin
                if (lt == 3'd1 || lt == 3'd2) begin
                    v = (mem >> (8 * lo)) & 32'hFF;
                    if (lt == 3'd1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
                end else if (lt == 3'd3 || lt == 3'd4) begin
                    v = (mem >> (16 * (lo / 2))) & 32'hFFFF;
                    if (lt == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end else begin
                    v = mem;
                end
                return v;
            end
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] lt, input logic [1:0] lo);
        if (lt == 3'd0) return (lo != 2'd0);
        if (lt == 3'd3 || lt == 3'd4) return (int'(lo) % 2 == 1);
        return 1'b0;
    endfunction

    // Advance the model from the currently driven inputs, then clock the DUT.
    task automatic step();
        logic mis;
        if (!rst_n) begin
            m_we = 0; m_mis = 0; m_addr = '0; m_bus = '0; m_cnt = 0;
        end else if (bus.flush_i) begin
            m_we = 0; m_mis = 0;
        end else if (bus.stall_i) begin
            m_mis = 0;
        end else begin
            mis    = bus.in_valid_i && bus.wb_sel_i == 2'd1 && ref_mis(bus.load_type_i, bus.alu_ans_i[1:0]);
            m_mis  = mis;
            m_we   = bus.in_valid_i && bus.reg_we_i && bus.rd_i != 0 && !mis;
            m_addr = bus.rd_i;
            m_bus  = ref_src(bus.wb_sel_i, bus.load_type_i, bus.alu_ans_i, bus.mem_data_i,
                             bus.pc_addr_i, bus.aux_data_i);
            if (bus.in_valid_i) m_cnt = (m_cnt + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid_i = 0; bus.stall_i = 0; bus.flush_i = 0;
        bus.alu_ans_i = '0; bus.mem_data_i = '0; bus.pc_addr_i = '0; bus.aux_data_i = '0;
        bus.wb_sel_i = 2'd0; bus.load_type_i = 3'd0; bus.reg_we_i = 0; bus.rd_i = '0;
    endtask

    task automatic set_instr(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                             input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] rd);
        bus.in_valid_i = 1; bus.stall_i = 0; bus.flush_i = 0;
        bus.wb_sel_i = sel; bus.load_type_i = lt; bus.alu_ans_i = alu;
        bus.mem_data_i = mem; bus.pc_addr_i = pc; bus.aux_data_i = $urandom;
        bus.reg_we_i = 1; bus.rd_i = rd;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        n_checks++; if (bus.wr_en_o !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %0h exp 0", bus.wr_en_o); end
        n_checks++; if (bus.wr_addr_o !== 5'd0) begin n_errors++; $display("FAIL reset_wr_addr got %0h exp 0", bus.wr_addr_o); end
        n_checks++; if (bus.busW_o !== 32'd0) begin n_errors++; $display("FAIL reset_busW got %0h exp 0", bus.busW_o); end
        n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL reset_misalign got %0h exp 0", bus.misalign_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got %0h exp 0", bus.retire_cnt_o); end
    endtask

    task automatic test_lb_signed();
        set_instr(2'd1, 3'd1, 32'h1000_0001, 32'h1234_80FF, 32'h0, 5'd5);
        step();
        n_checks++; if (bus.wr_en_o !== 1'b1) begin n_errors++; $display("FAIL lb_wr_en got %0h exp 1", bus.wr_en_o); end
        n_checks++; if (bus.wr_addr_o !== 5'd5) begin n_errors++; $display("FAIL lb_wr_addr got %0h exp 5", bus.wr_addr_o); end
        n_checks++; if (bus.busW_o !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_busW got %0h exp ffffff80", bus.busW_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd1) begin n_errors++; $display("FAIL lb_cnt got %0h exp 1", bus.retire_cnt_o); end
    endtask

    task automatic test_lhu_misalign();
        set_instr(2'd1, 3'd4, 32'h2000_0002, 32'h8001_7FFF, 32'h0, 5'd6);
        step();
        n_checks++; if (bus.busW_o !== 32'h0000_8001) begin n_errors++; $display("FAIL lhu_busW got %0h exp 8001", bus.busW_o); end
        n_checks++; if (bus.wr_en_o !== 1'b1) begin n_errors++; $display("FAIL lhu_wr_en got %0h exp 1", bus.wr_en_o); end
        set_instr(2'd1, 3'd3, 32'h2000_0001, 32'h8001_7FFF, 32'h0, 5'd6);
        step();
        n_checks++; if (bus.wr_en_o !== 1'b0) begin n_errors++; $display("FAIL lh_mis_wr_en got %0h exp 0", bus.wr_en_o); end
        n_checks++; if (bus.misalign_o !== 1'b1) begin n_errors++; $display("FAIL lh_mis_pulse got %0h exp 1", bus.misalign_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd3) begin n_errors++; $display("FAIL lh_mis_cnt got %0h exp 3", bus.retire_cnt_o); end
        idle();
        step();
        n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL lh_mis_clear got %0h exp 0", bus.misalign_o); end
    endtask

    task automatic test_jal();
        set_instr(2'd2, 3'd0, 32'h0, 32'h0, 32'h0040_0010, 5'd31);
        step();
        n_checks++; if (bus.busW_o !== 32'h0040_0018) begin n_errors++; $display("FAIL jal_busW got %0h exp 400018", bus.busW_o); end
        n_checks++; if (bus.wr_en_o !== 1'b1) begin n_errors++; $display("FAIL jal_wr_en got %0h exp 1", bus.wr_en_o); end
        n_checks++; if (bus.wr_addr_o !== 5'd31) begin n_errors++; $display("FAIL jal_wr_addr got %0h exp 31", bus.wr_addr_o); end
        set_instr(2'd2, 3'd0, 32'h0, 32'h0, 32'h0040_0010, 5'd0);
        step();
        n_checks++; if (bus.wr_en_o !== 1'b0) begin n_errors++; $display("FAIL jal_r0_wr_en got %0h exp 0", bus.wr_en_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd5) begin n_errors++; $display("FAIL jal_r0_cnt got %0h exp 5", bus.retire_cnt_o); end
    endtask

    task automatic test_stall_flush();
        set_instr(2'd0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0, 5'd7);
        step();
        for (int i = 0; i < 3; i++) begin
            set_instr(2'd0, 3'd0, $urandom, $urandom, $urandom, 5'd9);
            bus.stall_i = 1;
            step();
            n_checks++; if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 5'd7 || bus.busW_o !== 32'hCAFE_0001)
                begin n_errors++; $display("FAIL stall_hold[%0d] got en=%0h a=%0h d=%0h exp en=1 a=7 d=cafe0001", i, bus.wr_en_o, bus.wr_addr_o, bus.busW_o); end
            n_checks++; if (bus.retire_cnt_o !== 4'd6) begin n_errors++; $display("FAIL stall_cnt[%0d] got %0h exp 6", i, bus.retire_cnt_o); end
        end
        bus.stall_i = 1; bus.flush_i = 1;
        step();
        n_checks++; if (bus.wr_en_o !== 1'b0) begin n_errors++; $display("FAIL flush_stall_wr_en got %0h exp 0", bus.wr_en_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd6) begin n_errors++; $display("FAIL flush_stall_cnt got %0h exp 6", bus.retire_cnt_o); end
        // misaligned word load then a stall: the pulse must not stretch
        set_instr(2'd1, 3'd0, 32'h0000_0002, 32'h1111_2222, 32'h0, 5'd3);
        step();
        n_checks++; if (bus.misalign_o !== 1'b1 || bus.wr_en_o !== 1'b0) begin n_errors++; $display("FAIL lw_mis got mis=%0h en=%0h exp mis=1 en=0", bus.misalign_o, bus.wr_en_o); end
        bus.stall_i = 1;
        step();
        n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL lw_mis_stall got %0h exp 0", bus.misalign_o); end
        n_checks++; if (bus.retire_cnt_o !== 4'd7) begin n_errors++; $display("FAIL lw_mis_cnt got %0h exp 7", bus.retire_cnt_o); end
        idle();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.stall_i     = ($urandom_range(0, 4) == 0);
            bus.flush_i     = ($urandom_range(0, 7) == 0);
            bus.wb_sel_i    = 2'($urandom_range(0, 3));
            bus.load_type_i = 3'($urandom_range(0, 4));
            bus.alu_ans_i   = $urandom;
            bus.mem_data_i  = $urandom;
            bus.pc_addr_i   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.aux_data_i  = $urandom;
            bus.reg_we_i    = ($urandom_range(0, 4) != 0);
            bus.rd_i        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            step();
            n_checks++; if (bus.wr_en_o !== m_we) begin n_errors++; $display("FAIL rnd_wr_en[%0d] got %0h exp %0h", i, bus.wr_en_o, m_we); end
            n_checks++; if (bus.misalign_o !== m_mis) begin n_errors++; $display("FAIL rnd_mis[%0d] got %0h exp %0h", i, bus.misalign_o, m_mis); end
            n_checks++; if (bus.retire_cnt_o !== 4'(m_cnt)) begin n_errors++; $display("FAIL rnd_cnt[%0d] got %0h exp %0h", i, bus.retire_cnt_o, m_cnt); end
            if (m_we) begin
                n_checks++; if (bus.busW_o !== m_bus || bus.wr_addr_o !== m_addr)
                    begin n_errors++; $display("FAIL rnd_write[%0d] got a=%0h d=%0h exp a=%0h d=%0h", i, bus.wr_addr_o, bus.busW_o, m_addr, m_bus); end
            end
        end
        idle();
        step();
    endtask

    task automatic test_wrap_and_reset();
        int exp_tail[3] = '{15, 0, 1};
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 14; i++) begin
            set_instr(2'd0, 3'd0, $urandom, 32'h0, 32'h0, 5'($urandom_range(1, 31)));
            step();
            n_checks++; if (bus.retire_cnt_o !== 4'(i + 1)) begin n_errors++; $display("FAIL wrap_fill[%0d] got %0h exp %0h", i, bus.retire_cnt_o, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            set_instr(2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 5'd12);
            step();
            n_checks++; if (bus.retire_cnt_o !== 4'(exp_tail[i])) begin n_errors++; $display("FAIL wrap[%0d] got %0h exp %0h", i, bus.retire_cnt_o, exp_tail[i]); end
        end
        set_instr(2'd0, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd20);
        bus.stall_i = 1; bus.flush_i = 1;
        rst_n = 0;
        step();
        n_checks++; if (bus.wr_en_o !== 1'b0 || bus.wr_addr_o !== 5'd0 || bus.busW_o !== 32'd0 || bus.misalign_o !== 1'b0 || bus.retire_cnt_o !== 4'd0)
            begin n_errors++; $display("FAIL mid_reset got en=%0h a=%0h d=%0h mis=%0h cnt=%0h exp all 0", bus.wr_en_o, bus.wr_addr_o, bus.busW_o, bus.misalign_o, bus.retire_cnt_o); end
        rst_n = 1;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lhu_misalign();
        test_jal();
        test_stall_flush();
        test_random();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
